vga_timing_param: RTL and testbench
===================================

Name: vga_timing_param

Overview:
Parametrised VGA timing and pixel-pipeline generator, successor to the fixed 640x480 static-display timing block. It derives a pixel tick from the system clock and generates h/v counters and sync pulses with configurable polarity. It also produces character-cell addressing for the font ROM path. Sync, blanking and RGB outputs are delayed by a configurable pipeline depth, so they stay aligned with downstream ROM/colour-lookup latency.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
CLK_DIV, 2, system clocks per pixel tick (>=1)
HS_POL, 0, hsync active level
VS_POL, 0, vsync active level
FONT_W, 8, glyph width (power of 2)
FONT_H, 16, glyph height (power of 2)
PIPE, 2, pixel ticks of delay applied to sync/blank/RGB (0..7)
CW, 10, coordinate width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
rgb_in  in  12  {r,g,b} 4:4:4 pixel from the colour path, valid PIPE ticks after px/py
px  out  CW  current horizontal count (0..H_TOTAL-1)
py  out  CW  current vertical count (0..V_TOTAL-1)
pix_tick  out  1  one-clk pulse per pixel
video_on  out  1  px<H_ACTIVE && py<V_ACTIVE (undelayed)
char_col  out  CW  px/FONT_W
char_row  out  CW  py/FONT_H
glyph_line  out  log2(FONT_H)  py%FONT_H
glyph_bit  out  log2(FONT_W)  px%FONT_W
frame_start  out  1  one-tick pulse when px=0,py=0
hsy  out  1  delayed hsync
vsy  out  1  delayed vsync
ro, go, bo  out  4 each  delayed, blank-gated colour

Behaviour:
- H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Reset (reset=0, async): divider, px, py = 0; pix_tick, frame_start = 0; hsy=~HS_POL, vsy=~VS_POL; ro/go/bo=0; delay lines cleared to the inactive-sync/blank state.
- Divider: counts 0..CLK_DIV-1. pix_tick=1 for the clk where count=CLK_DIV-1. CLK_DIV=1 gives pix_tick constantly high.
- On pix_tick: px increments. At px=H_TOTAL-1, px wraps to 0 and py increments. At py=V_TOTAL-1 with the line wrap, py wraps to 0.
- px/py are registered. The char/glyph outputs are combinational slices/shifts of px/py, with zero additional latency.
- Raw hsync is active for H_ACTIVE+H_FP <= px < H_ACTIVE+H_FP+H_SYNC. Raw vsync is active for V_ACTIVE+V_FP <= py < V_ACTIVE+V_FP+V_SYNC.
- frame_start is asserted for the whole tick period in which px=0,py=0.
- Delay line: a PIPE-stage shift register of {hs_raw, vs_raw, video_on} that advances only on pix_tick. PIPE=0 passes signals through combinationally.
- Output register, updated on pix_tick:
  - hsy = HS_POL ? hs_d : ~hs_d; vsy likewise.
  - {ro,go,bo} = von_d ? rgb_in : 0.
  - Net output latency: PIPE+1 ticks from the px/py value.
- Outputs hold between ticks.
- Reset asserted mid-frame: all state clears immediately. After release, the timing restarts at px=0,py=0, and the first frame_start occurs on the first tick period.

Decomposition:
- Shared package vga_pkg: 640x480@60 timing constants, the RGB444 width (12), and helper functions h_total/v_total/clog2.
- One sub-module: vga_delay_line (parametrised width, depth, enable), used for sync/blank alignment.

Test Plan:
- Reset hold then release, defaults -> px=py=0, hsy=vsy=1, rgb=0; pix_tick every 2nd clk (period 40 ns at 20 ns clk).
- Run one line -> px wraps 799->0 after 800 ticks (32000 ns). Raw hsync low for px 656..751, and hsy falls PIPE+1=3 ticks after px=656.
- Run one full frame -> vsy low only while delayed py is 490..491. frame_start pulses are 420000 ticks apart (16.8 ms).
- rgb_in=12'hF0A constant -> ro/go/bo=F/0/A only during delayed active region. Output is 0 at px 640..799 (shifted by 3 ticks) and on lines >=480.
- px=37, py=35 -> char_col=4, glyph_bit=5, char_row=2, glyph_line=3.
- Reset pulsed at px=300, py=200 -> outputs return to reset values within the same clk. After release, counting restarts from 0,0. Rerun with CLK_DIV=1, HS_POL=1 -> tick every clk, hsy active-high.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared constants and helpers for the parametrised VGA timing block.
// Holds the 640x480@60 default timing, the RGB444 pixel width and small
// elaboration-time helpers (line/frame totals, ceil-log2).
package vga_pkg;

  // 640x480@60 default timing, in pixels / lines
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  // {r,g,b} 4:4:4
  localparam int RGB_W = 12;

  function automatic int h_total(input int act, input int fp, input int sw, input int bp);
    return act + fp + sw + bp;
  endfunction

  function automatic int v_total(input int act, input int fp, input int sw, input int bp);
    return act + fp + sw + bp;
  endfunction

  // ceil(log2(v)); 0 for v<=1
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Enable-gated shift register used to align sync/blank with the colour path.
// Ports:
//   clk   - system clock
//   reset - asynchronous, active-low; clears every stage to 0
//   en    - advance the line by one stage
//   din   - value entering the line
//   dout  - value leaving the line (DEPTH advances later); DEPTH=0 is a wire
module vga_delay_line #(
  parameter int W     = 1,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign dout = din;
    end else begin : g_pipe
      logic [W-1:0] stage_reg [DEPTH];

      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        if (gi == 0) begin : g_head
          always_ff @(posedge clk or negedge reset) begin
            if (!reset)  stage_reg[gi] <= '0;
            else if (en) stage_reg[gi] <= din;
          end
        end else begin : g_tail
          always_ff @(posedge clk or negedge reset) begin
            if (!reset)  stage_reg[gi] <= '0;
            else if (en) stage_reg[gi] <= stage_reg[gi-1];
          end
        end
      end

      assign dout = stage_reg[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_param.sv
// Parametrised VGA timing generator with character-cell addressing and a
// sync/blank/RGB pipeline that matches downstream ROM/colour-lookup latency.
// Ports:
//   clk, reset (async, active-low)
//   rgb_in      - {r,g,b} pixel, valid PIPE ticks after the px/py it belongs to
//   px, py      - registered pixel/line counters
//   pix_tick    - one-clk pulse per pixel period
//   video_on    - undelayed active-area flag
//   char_col/char_row/glyph_line/glyph_bit - font addressing from px/py
//   frame_start - high for the whole pixel period at px=0,py=0
//   hsy, vsy    - delayed syncs with configured polarity
//   ro, go, bo  - delayed, blank-gated colour
module vga_timing_param
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter int CLK_DIV  = 2,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int FONT_W   = 8,
  parameter int FONT_H   = 16,
  parameter int PIPE     = 2,
  parameter int CW       = 10
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [RGB_W-1:0]          rgb_in,
  output logic [CW-1:0]             px,
  output logic [CW-1:0]             py,
  output logic                      pix_tick,
  output logic                      video_on,
  output logic [CW-1:0]             char_col,
  output logic [CW-1:0]             char_row,
  output logic [clog2(FONT_H)-1:0]  glyph_line,
  output logic [clog2(FONT_W)-1:0]  glyph_bit,
  output logic                      frame_start,
  output logic                      hsy,
  output logic                      vsy,
  output logic [3:0]                ro,
  output logic [3:0]                go,
  output logic [3:0]                bo
);

  localparam int H_TOT = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOT = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int DW    = (CLK_DIV > 1) ? clog2(CLK_DIV) : 1;
  localparam int FWB   = clog2(FONT_W);
  localparam int FHB   = clog2(FONT_H);
  localparam logic HS_ACT = HS_POL[0];
  localparam logic VS_ACT = VS_POL[0];

  logic [DW-1:0] div_reg, div_next;
  logic          tick_reg;
  logic          alive_reg;
  logic [CW-1:0] px_reg, py_reg;
  logic          hs_raw, vs_raw;
  logic          hs_d, vs_d, von_d;

  // With CLK_DIV=1 the compare is always true, so the tick stays high.
  assign div_next = (div_reg == DW'(CLK_DIV - 1)) ? '0 : div_reg + DW'(1);

  // The tick is registered so it reads 0 during reset even when CLK_DIV=1;
  // out of reset it is high exactly while div_reg == CLK_DIV-1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_reg   <= '0;
      tick_reg  <= 1'b0;
      alive_reg <= 1'b0;
      px_reg    <= '0;
      py_reg    <= '0;
    end else begin
      div_reg   <= div_next;
      tick_reg  <= (div_next == DW'(CLK_DIV - 1));
      alive_reg <= 1'b1;
      if (tick_reg) begin
        if (px_reg == CW'(H_TOT - 1)) begin
          px_reg <= '0;
          py_reg <= (py_reg == CW'(V_TOT - 1)) ? '0 : py_reg + CW'(1);
        end else begin
          px_reg <= px_reg + CW'(1);
        end
      end
    end
  end

  assign px       = px_reg;
  assign py       = py_reg;
  assign pix_tick = tick_reg;
  assign video_on = (px_reg < CW'(H_ACTIVE)) && (py_reg < CW'(V_ACTIVE));

  // Font sizes are powers of two, so division/modulo are shifts/slices.
  assign char_col   = px_reg >> FWB;
  assign char_row   = py_reg >> FHB;
  assign glyph_bit  = px_reg[FWB-1:0];
  assign glyph_line = py_reg[FHB-1:0];

  // alive_reg keeps frame_start low in reset although px=py=0 there, while
  // still flagging the very first period after release.
  assign frame_start = alive_reg && (px_reg == '0) && (py_reg == '0);

  // Raw syncs are active-high internally; polarity is applied at the output.
  assign hs_raw = (px_reg >= CW'(H_ACTIVE + H_FP)) && (px_reg < CW'(H_ACTIVE + H_FP + H_SYNC));
  assign vs_raw = (py_reg >= CW'(V_ACTIVE + V_FP)) && (py_reg < CW'(V_ACTIVE + V_FP + V_SYNC));

  vga_delay_line #(
    .W     (3),
    .DEPTH (PIPE)
  ) u_delay (
    .clk   (clk),
    .reset (reset),
    .en    (tick_reg),
    .din   ({hs_raw, vs_raw, video_on}),
    .dout  ({hs_d, vs_d, von_d})
  );

  // Final register adds the one extra tick: net latency is PIPE+1 ticks.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hsy <= ~HS_ACT;
      vsy <= ~VS_ACT;
      ro  <= '0;
      go  <= '0;
      bo  <= '0;
    end else if (tick_reg) begin
      hsy          <= HS_ACT ? hs_d : ~hs_d;
      vsy          <= VS_ACT ? vs_d : ~vs_d;
      {ro, go, bo} <= von_d ? rgb_in : '0;
    end
  end

endmodule

// File: tb/tb_vga_timing_param.sv
// Self-checking bench: two instances (default 640x480 timing, and a tiny
// CLK_DIV=1 / active-high / PIPE=0 configuration) compared every clock
// against a pixel-index model of the raster.
module tb_vga_timing_param;

  typedef struct packed {
    int h_act; int h_fp; int h_sw; int h_bp;
    int v_act; int v_fp; int v_sw; int v_bp;
    int div;   int hs_pol; int vs_pol;
    int font_w; int font_h; int pipe;
  } cfg_t;

  localparam cfg_t CFG_A = '{h_act:640, h_fp:16, h_sw:96, h_bp:48,
                             v_act:480, v_fp:10, v_sw:2, v_bp:33,
                             div:2, hs_pol:0, vs_pol:0,
                             font_w:8, font_h:16, pipe:2};
  localparam cfg_t CFG_B = '{h_act:16, h_fp:2, h_sw:3, h_bp:3,
                             v_act:8, v_fp:1, v_sw:2, v_bp:1,
                             div:1, hs_pol:1, vs_pol:1,
                             font_w:4, font_h:2, pipe:0};

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic        rst_a, rst_b;
  logic [11:0] rgb_a, rgb_b;

  logic [9:0] px_a, py_a, cc_a, cr_a;
  logic [3:0] gl_a;
  logic [2:0] gb_a;
  logic       tick_a, von_a, fs_a, hsy_a, vsy_a;
  logic [3:0] ro_a, go_a, bo_a;

  logic [9:0] px_b, py_b, cc_b, cr_b;
  logic [0:0] gl_b;
  logic [1:0] gb_b;
  logic       tick_b, von_b, fs_b, hsy_b, vsy_b;
  logic [3:0] ro_b, go_b, bo_b;

  vga_timing_param #(
    .H_ACTIVE(CFG_A.h_act), .H_FP(CFG_A.h_fp), .H_SYNC(CFG_A.h_sw), .H_BP(CFG_A.h_bp),
    .V_ACTIVE(CFG_A.v_act), .V_FP(CFG_A.v_fp), .V_SYNC(CFG_A.v_sw), .V_BP(CFG_A.v_bp),
    .CLK_DIV(CFG_A.div), .HS_POL(CFG_A.hs_pol), .VS_POL(CFG_A.vs_pol),
    .FONT_W(CFG_A.font_w), .FONT_H(CFG_A.font_h), .PIPE(CFG_A.pipe), .CW(10)
  ) dut_a (
    .clk(clk), .reset(rst_a), .rgb_in(rgb_a), .px(px_a), .py(py_a),
    .pix_tick(tick_a), .video_on(von_a), .char_col(cc_a), .char_row(cr_a),
    .glyph_line(gl_a), .glyph_bit(gb_a), .frame_start(fs_a),
    .hsy(hsy_a), .vsy(vsy_a), .ro(ro_a), .go(go_a), .bo(bo_a)
  );

  vga_timing_param #(
    .H_ACTIVE(CFG_B.h_act), .H_FP(CFG_B.h_fp), .H_SYNC(CFG_B.h_sw), .H_BP(CFG_B.h_bp),
    .V_ACTIVE(CFG_B.v_act), .V_FP(CFG_B.v_fp), .V_SYNC(CFG_B.v_sw), .V_BP(CFG_B.v_bp),
    .CLK_DIV(CFG_B.div), .HS_POL(CFG_B.hs_pol), .VS_POL(CFG_B.vs_pol),
    .FONT_W(CFG_B.font_w), .FONT_H(CFG_B.font_h), .PIPE(CFG_B.pipe), .CW(10)
  ) dut_b (
    .clk(clk), .reset(rst_b), .rgb_in(rgb_b), .px(px_b), .py(py_b),
    .pix_tick(tick_b), .video_on(von_b), .char_col(cc_b), .char_row(cr_b),
    .glyph_line(gl_b), .glyph_bit(gb_b), .frame_start(fs_b),
    .hsy(hsy_b), .vsy(vsy_b), .ro(ro_b), .go(go_b), .bo(bo_b)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    tests_run++;
    if (obs != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: e = clock edges since reset release, t = pixel periods since
  // release. A pixel period ends on every edge preceded by a tick clock.
  longint      e_a = 0, t_a = 0, e_b = 0, t_b = 0;
  logic [11:0] hist_a [8];
  logic [11:0] hist_b [8];

  function automatic bit tick_expected(input cfg_t c, input longint e);
    return (e >= 1) && ((e % c.div) == c.div - 1);
  endfunction

  always @(posedge clk) begin
    if (!rst_a) begin
      e_a <= 0; t_a <= 0;
    end else begin
      if (tick_expected(CFG_A, e_a)) begin
        hist_a[t_a % 8] <= rgb_a;
        t_a <= t_a + 1;
      end
      e_a <= e_a + 1;
    end
  end

  always @(posedge clk) begin
    if (!rst_b) begin
      e_b <= 0; t_b <= 0;
    end else begin
      if (tick_expected(CFG_B, e_b)) begin
        hist_b[t_b % 8] <= rgb_b;
        t_b <= t_b + 1;
      end
      e_b <= e_b + 1;
    end
  end

  // Raster position and raw timing flags of pixel period t.
  function automatic void pos_at(input cfg_t c, input longint t,
                                 output int x, output int y,
                                 output bit hs, output bit vs, output bit von);
    longint ht, vt, p;
    ht  = c.h_act + c.h_fp + c.h_sw + c.h_bp;
    vt  = c.v_act + c.v_fp + c.v_sw + c.v_bp;
    p   = t % (ht * vt);
    x   = int'(p % ht);
    y   = int'(p / ht);
    hs  = (x >= c.h_act + c.h_fp) && (x < c.h_act + c.h_fp + c.h_sw);
    vs  = (y >= c.v_act + c.v_fp) && (y < c.v_act + c.v_fp + c.v_sw);
    von = (x < c.h_act) && (y < c.v_act);
  endfunction

  task automatic check_inst(input string n, input cfg_t c, input longint e, input longint t,
                            input logic [11:0] rgb_prev,
                            input int o_px, input int o_py, input int o_tick, input int o_von,
                            input int o_cc, input int o_cr, input int o_gl, input int o_gb,
                            input int o_fs, input int o_hsy, input int o_vsy, input int o_rgb);
    int x, y, dx, dy;
    bit hs, vs, von, dhs, dvs, dvon;
    pos_at(c, t, x, y, hs, vs, von);
    dhs = 0; dvs = 0; dvon = 0;
    if (t >= c.pipe + 1) pos_at(c, t - c.pipe - 1, dx, dy, dhs, dvs, dvon);
    chk({n, ".px"},          o_px,   x);
    chk({n, ".py"},          o_py,   y);
    chk({n, ".pix_tick"},    o_tick, tick_expected(c, e));
    chk({n, ".video_on"},    o_von,  von);
    chk({n, ".char_col"},    o_cc,   x / c.font_w);
    chk({n, ".char_row"},    o_cr,   y / c.font_h);
    chk({n, ".glyph_line"},  o_gl,   y % c.font_h);
    chk({n, ".glyph_bit"},   o_gb,   x % c.font_w);
    chk({n, ".frame_start"}, o_fs,   (e >= 1) && x == 0 && y == 0);
    chk({n, ".hsy"},         o_hsy,  (c.hs_pol != 0) ? dhs : !dhs);
    chk({n, ".vsy"},         o_vsy,  (c.vs_pol != 0) ? dvs : !dvs);
    chk({n, ".rgb"},         o_rgb,  dvon ? rgb_prev : 12'h000);
  endtask

  always @(negedge clk) begin
    #2;
    check_inst("a", CFG_A, rst_a ? e_a : 0, rst_a ? t_a : 0,
               (rst_a && t_a > 0) ? hist_a[(t_a - 1) % 8] : 12'h000,
               px_a, py_a, tick_a, von_a, cc_a, cr_a, gl_a, gb_a,
               fs_a, hsy_a, vsy_a, {ro_a, go_a, bo_a});
    check_inst("b", CFG_B, rst_b ? e_b : 0, rst_b ? t_b : 0,
               (rst_b && t_b > 0) ? hist_b[(t_b - 1) % 8] : 12'h000,
               px_b, py_b, tick_b, von_b, cc_b, cr_b, gl_b, gb_b,
               fs_b, hsy_b, vsy_b, {ro_b, go_b, bo_b});
  end

  initial begin
    bit reached;
    int rb;
    rst_a = 1'b0; rst_b = 1'b0;
    rgb_a = 12'hF0A; rgb_b = 12'h000;
    repeat (5) @(negedge clk);
    rst_a = 1'b1; rst_b = 1'b1;

    // Constant colour on A across a full line; random colour on B.
    reached = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rgb_b = 12'($urandom);
      if (t_a == 1100) begin
        reached = 1'b1;
        break;
      end
    end
    chk("a.reach_px300_py1", reached, 1);

    // Asynchronous reset mid-line (A at px=300, py=1).
    rst_a = 1'b0; rst_b = 1'b0;
    repeat (3) begin
      @(negedge clk);
      rgb_a = 12'($urandom);
      rgb_b = 12'($urandom);
    end
    rst_a = 1'b1; rst_b = 1'b1;

    // Random colour on both; B gets one more short reset at a random point.
    rb = int'($urandom_range(300, 1500));
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      rgb_a = 12'($urandom);
      rgb_b = 12'($urandom);
      rst_b = (i >= rb && i < rb + 2) ? 1'b0 : 1'b1;
    end
    @(negedge clk);
    #5;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
